// File: rtl/ifq_line_reader.sv
// ifq_line_reader: slices fetch lines from the IFQ buffer head into single
// instructions for decode. It pulls the head line once its last word is
// consumed, and re-aligns to a new PC on flush/redirect.
module ifq_line_reader #(
    parameter int          LENGTH   = 128,
    parameter int          WORD     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [31:0]       redirect_pc,
    input  logic [LENGTH-1:0] line_data,
    input  logic              line_empty,
    output logic              pull,
    output logic [WORD-1:0]   instr_out,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    localparam int              WORDS      = LENGTH / WORD;
    localparam int              IDXW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int              BOFF       = $clog2(WORD / 8);
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(WORDS - 1);
    localparam logic [IDXW-1:0] IDX_ONE    = IDXW'(1);
    localparam logic [31:0]     PC_STEP    = 32'(WORD / 8);
    localparam logic [31:0]     ALIGN_MASK = ~(32'(WORD / 8) - 32'd1);

    typedef enum logic {
        EMPTY,
        HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] word_idx_q, word_idx_d;
    logic [31:0]     next_pc_q, next_pc_d;
    logic [WORD-1:0] instr_out_q, instr_out_d;
    logic [31:0]     instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            load;
    logic [WORD-1:0] line_words [WORDS];

    for (genvar g = 0; g < WORDS; g++) begin : g_slice
        assign line_words[g] = line_data[g*WORD +: WORD];
    end

    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

    // Next-state logic: flush beats load, load beats draining to EMPTY.
    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        next_pc_d     = next_pc_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        load          = !flush && !line_empty && (state_q == EMPTY || instr_ready);
        pull          = rst && load && (word_idx_q == LAST_IDX);

        if (flush) begin
            instr_valid_d = 1'b0;
            state_d       = EMPTY;
            next_pc_d     = redirect_pc & ALIGN_MASK;
            word_idx_d    = redirect_pc[BOFF+IDXW-1:BOFF];
        end else if (load) begin
            instr_out_d   = line_words[word_idx_q];
            instr_pc_d    = next_pc_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
            next_pc_d     = next_pc_q + PC_STEP;
            word_idx_d    = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + IDX_ONE;
        end else if (state_q == HOLD && instr_ready) begin
            instr_valid_d = 1'b0;
            state_d       = EMPTY;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= EMPTY;
            word_idx_q    <= RESET_PC[BOFF+IDXW-1:BOFF];
            next_pc_q     <= RESET_PC;
            instr_out_q   <= '0;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_idx_q    <= word_idx_d;
            next_pc_q     <= next_pc_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

endmodule

// File: tb/tb_ifq_line_reader.sv
// tb_ifq_line_reader: scoreboard bench for ifq_line_reader with a small
// behavioural IFQ buffer model driving line_data/line_empty.
module tb_ifq_line_reader;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [31:0]  redirect_pc;
    logic [127:0] line_data;
    logic         line_empty;
    logic         pull;
    logic [31:0]  instr_out;
    logic [31:0]  instr_pc;
    logic         instr_valid;
    logic         instr_ready;

    int cmpCount  = 0;
    int failCount = 0;

    logic [127:0] bufQ [$];
    logic [31:0]  expInstrQ [$];
    logic [31:0]  expPcQ [$];
    logic [31:0]  expPullQ [$];

    logic         doPop;
    logic         doClr;
    logic         prevPull = 1'b0;
    logic [31:0]  monInstr;
    logic [31:0]  monPc;
    logic [31:0]  monPull;

    ifq_line_reader #(
        .LENGTH  (128),
        .WORD    (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .redirect_pc(redirect_pc),
        .line_data  (line_data),
        .line_empty (line_empty),
        .pull       (pull),
        .instr_out  (instr_out),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmpCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic updateHead();
        line_empty = (bufQ.size() == 0);
        line_data  = (bufQ.size() == 0) ? '0 : bufQ[0];
    endtask

    task automatic applyStimulus(input logic [127:0] line);
        bufQ.push_back(line);
        updateHead();
    endtask

    task automatic expectInstr(input logic [31:0] data, input logic [31:0] pc);
        expInstrQ.push_back(data);
        expPcQ.push_back(pc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic startTest();
        rst         = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        bufQ.delete();
        updateHead();
        tick(1);
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_instr_left"}, 32'(expInstrQ.size()), 32'd0);
        checkOutput({tag, "_pull_left"}, 32'(expPullQ.size()), 32'd0);
        expInstrQ.delete();
        expPcQ.delete();
        expPullQ.delete();
    endtask

    // IFQ buffer model: pops the head on pull, empties on flush, just after the edge.
    always @(posedge clk) begin
        doPop = pull;
        doClr = flush;
        #1;
        if (doClr) begin
            bufQ.delete();
        end else if (doPop) begin
            if (bufQ.size() == 0) begin
                cmpCount++;
                failCount++;
                $display("[TB] FAIL pull_on_empty: got pull=1, expected 0");
            end else begin
                void'(bufQ.pop_front());
            end
        end
        updateHead();
    end

    // Monitor: compares accepted instructions and pulled-word PCs against the scoreboard.
    always @(negedge clk) begin
        if (rst && instr_valid && instr_ready && !flush) begin
            if (expInstrQ.size() == 0) begin
                cmpCount++;
                failCount++;
                $display("[TB] FAIL unexpected_instr: got %h at pc %h, expected none", instr_out, instr_pc);
            end else begin
                monInstr = expInstrQ.pop_front();
                monPc    = expPcQ.pop_front();
                checkOutput("instr_out", instr_out, monInstr);
                checkOutput("instr_pc", instr_pc, monPc);
            end
        end
        if (prevPull && instr_valid) begin
            if (expPullQ.size() == 0) begin
                cmpCount++;
                failCount++;
                $display("[TB] FAIL unexpected_pull: got pull for pc %h, expected none", instr_pc);
            end else begin
                monPull = expPullQ.pop_front();
                checkOutput("pull_word_pc", instr_pc, monPull);
            end
        end
        if (line_empty || flush) begin
            checkOutput("pull_blocked", {31'd0, pull}, 32'd0);
        end
        prevPull = pull;
    end

    initial begin
        redirect_pc = '0;
        startTest();

        // Test 1: reset values, then stream two lines at full rate.
        @(negedge clk);
        checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_out", instr_out, 32'd0);
        checkOutput("rst_pc", instr_pc, 32'd0);
        checkOutput("rst_pull", {31'd0, pull}, 32'd0);
        tick(1);
        applyStimulus({32'h4, 32'h3, 32'h2, 32'h1});
        applyStimulus({32'h8, 32'h7, 32'h6, 32'h5});
        for (int i = 0; i < 8; i++) expectInstr(32'(i + 1), 32'(i * 4));
        expPullQ.push_back(32'h0C);
        expPullQ.push_back(32'h1C);
        instr_ready = 1'b1;
        rst         = 1'b1;
        tick(9);
        checkDrained("t1");
        @(negedge clk);
        checkOutput("t1_valid_drop", {31'd0, instr_valid}, 32'd0);

        // Test 2 + 4: backpressure, then underflow and refill.
        startTest();
        applyStimulus({32'h4, 32'h3, 32'h2, 32'h1});
        for (int i = 0; i < 4; i++) expectInstr(32'(i + 1), 32'(i * 4));
        expPullQ.push_back(32'h0C);
        instr_ready = 1'b1;
        rst         = 1'b1;
        tick(2);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_out", instr_out, 32'h2);
            checkOutput("bp_pc", instr_pc, 32'h4);
            checkOutput("bp_valid", {31'd0, instr_valid}, 32'd1);
            checkOutput("bp_pull", {31'd0, pull}, 32'd0);
            tick(1);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("resume_out", instr_out, 32'h3);
        checkOutput("resume_pc", instr_pc, 32'h8);
        tick(3);
        checkDrained("t2");
        @(negedge clk);
        checkOutput("uf_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("uf_pull", {31'd0, pull}, 32'd0);
        tick(1);
        applyStimulus({32'h8, 32'h7, 32'h6, 32'h5});
        for (int i = 4; i < 8; i++) expectInstr(32'(i + 1), 32'(i * 4));
        expPullQ.push_back(32'h1C);
        @(negedge clk);
        checkOutput("refill_wait", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        checkOutput("refill_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("refill_pc", instr_pc, 32'h10);
        checkOutput("refill_out", instr_out, 32'h5);
        tick(6);
        checkDrained("t4");

        // Test 3: redirect into the middle of a line.
        startTest();
        instr_ready = 1'b1;
        rst         = 1'b1;
        tick(2);
        flush       = 1'b1;
        redirect_pc = 32'h0000_1008;
        tick(1);
        flush = 1'b0;
        applyStimulus({32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000});
        expectInstr(32'hCCCC_0002, 32'h1008);
        expectInstr(32'hDDDD_0003, 32'h100C);
        expPullQ.push_back(32'h100C);
        tick(5);
        checkDrained("t3");
        @(negedge clk);
        checkOutput("t3_valid_drop", {31'd0, instr_valid}, 32'd0);

        // Test 5: flush in the cycle the last word would load; misaligned redirect.
        startTest();
        applyStimulus({32'h4, 32'h3, 32'h2, 32'h1});
        applyStimulus({32'h8, 32'h7, 32'h6, 32'h5});
        expectInstr(32'h1, 32'h0);
        expectInstr(32'h2, 32'h4);
        instr_ready = 1'b1;
        rst         = 1'b1;
        tick(3);
        flush       = 1'b1;
        redirect_pc = 32'h0000_2006;
        @(negedge clk);
        checkOutput("fl_pull", {31'd0, pull}, 32'd0);
        checkOutput("fl_out", instr_out, 32'h3);
        tick(1);
        flush = 1'b0;
        @(negedge clk);
        checkOutput("fl_valid", {31'd0, instr_valid}, 32'd0);
        tick(1);
        applyStimulus({32'h44, 32'h33, 32'h22, 32'h11});
        expectInstr(32'h22, 32'h2004);
        expectInstr(32'h33, 32'h2008);
        expectInstr(32'h44, 32'h200C);
        expPullQ.push_back(32'h200C);
        tick(6);
        checkDrained("t5");

        // Test 6: asynchronous reset between clock edges.
        startTest();
        applyStimulus({32'h4, 32'h3, 32'h2, 32'h1});
        expectInstr(32'h1, 32'h0);
        expectInstr(32'h2, 32'h4);
        instr_ready = 1'b1;
        rst         = 1'b1;
        tick(3);
        #1;
        checkOutput("pre_rst_pull", {31'd0, pull}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("arst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("arst_pull", {31'd0, pull}, 32'd0);
        checkOutput("arst_pc", instr_pc, 32'h0);
        tick(1);
        for (int i = 0; i < 4; i++) expectInstr(32'(i + 1), 32'(i * 4));
        expPullQ.push_back(32'h0C);
        rst = 1'b1;
        tick(8);
        checkDrained("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", cmpCount, failCount);
        $finish;
    end

endmodule
